nco_freq_meter: RTL and testbench
=================================

Name: nco_freq_meter

Overview:
- Measurement-side counterpart to the simple_nco generator: takes the 8-bit NCO output stream and recovers its frequency.
- Rising edges of the sample MSB are counted over a fixed gate window of 2^GATE_LOG2 clocks.
- The clock distance between successive rising edges is also measured.
- Used for on-chip self-check and loopback of the NCO; results are presented with a one-cycle valid strobe.

Parameters:
- DATA_W, 8: sample width; the MSB (sampleIn[DATA_W-1]) is the edge source.
- GATE_LOG2, 8: gate window length = 2^GATE_LOG2 clocks.
- CNT_W, 16: width of freqOut, periodOut and the internal counters; must be >= GATE_LOG2+1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  measurement enable
- sampleIn  input  DATA_W  NCO output sample
- freqOut  output  CNT_W  rising edges counted in the last completed window
- periodOut  output  CNT_W  clocks between the last two rising edges
- valid  output  1  one-cycle strobe; freqOut/periodOut/noSignal updated this cycle
- noSignal  output  1  last window closed with zero edges
- periodSat  output  1  periodOut clamped at 2^CNT_W-1

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. Everything is clocked on the rising edge of clk.
- Reset:
  - State goes to IDLE; all counters and all outputs go to 0.
  - prevMsb goes to 0.
  - Reset asserted mid-window discards all partial counts; outputs read 0 on the cycle after rst is sampled high.
- Edge detect:
  - prevMsb <= sampleIn[DATA_W-1] on every cycle, regardless of state or enable.
  - rise = sampleIn[DATA_W-1] & ~prevMsb.
- States:
  - IDLE: counters held at 0; valid=0; outputs hold their last values. enable=1 -> ARM.
  - ARM (waiting for the aligning edge):
    - The gate counter runs.
    - On rise -> MEASURE. That cycle is gate cycle 0, edge count = 1, period counter restarts.
    - If the gate counter reaches 2^GATE_LOG2-1 with no rise:
      - Next cycle: valid=1, freqOut=0, periodOut=0, noSignal=1.
      - Stay in ARM; the gate counter wraps.
  - MEASURE:
    - The gate counter increments every cycle; edgeCnt increments on each rise.
    - On the last gate cycle (count 2^GATE_LOG2-1):
      - A rise on that cycle counts toward the closing window.
      - Next cycle: valid=1, freqOut=final edge count, noSignal=(count==0).
      - The new window starts with edgeCnt=0 and the gate counter wrapped. No dead cycle between windows; a rise on the first cycle of the new window counts in the new window.
      - If the count was 0 -> ARM, otherwise stay in MEASURE.
  - enable=0 in any state: -> IDLE on the next cycle; the partial window is discarded; no valid.
- Period:
  - The period counter counts clocks since the last rise.
  - On each rise after the arming edge, the distance in clocks is latched. For edges at cycles t and t+P, latch P.
  - The latch goes to an internal register; periodOut is updated only with valid.
  - If the distance exceeds 2^CNT_W-1: clamp to 2^CNT_W-1 and set periodSat. periodSat clears at the next window report whose period did not clamp.
  - periodOut reports the most recent completed period at window close. If no second edge occurred since arming, report 0.
- Output timing: freqOut, periodOut, noSignal and periodSat are registered and change only in the valid cycle. valid is high for exactly one cycle per window.
- Latency: first valid = arming-edge cycle + 2^GATE_LOG2.
- edgeCnt saturates at 2^CNT_W-1; it cannot wrap.

Test Plan:
- Reset mid-MEASURE:
  - Run FTW=16 for 100 cycles, hold rst high 2 cycles.
  - Expect all outputs 0 and no valid.
  - After release with enable=1: re-arm and first valid 256 cycles after the next rise.
- Sawtooth, FTW=16 (sampleIn = 8-bit accumulator += 16, enable=1):
  - valid at arming edge + 256, freqOut=16, periodOut=16, noSignal=0.
  - Repeats every 256 cycles with identical values.
- Slowest tone, FTW=1:
  - freqOut=1, periodOut=0 in the first window.
  - freqOut=1, periodOut=256 in subsequent windows.
- DC input (sampleIn=0x00, enable=1):
  - valid every 256 cycles, freqOut=0, periodOut=0, noSignal=1.
  - State stays ARM.
  - Switching to FTW=16 gives a normal report 256 cycles after its first rise.
- Enable drop:
  - FTW=16; deassert enable 100 cycles into a window for 50 cycles.
  - No valid while low; outputs hold the previous report (16/16).
  - After re-enable: re-arm, next valid 256 cycles after the next rise, values 16/16.
- Max rate (sampleIn alternating 0x80/0x00 every cycle):
  - freqOut=128, periodOut=2.
  - A rise on gate cycle 255 counts in the closing window.

Source files
------------

// File: rtl/nco_freq_meter_if.sv
// Bus between the NCO frequency meter and its user: enable and sample in,
// measurement results and the one-cycle report strobe out.
interface nco_freq_meter_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              enable;
  logic [DATA_W-1:0] sampleIn;
  logic [CNT_W-1:0]  freqOut;
  logic [CNT_W-1:0]  periodOut;
  logic              valid;
  logic              noSignal;
  logic              periodSat;

  modport master (
    output enable, sampleIn,
    input  freqOut, periodOut, valid, noSignal, periodSat
  );

  modport slave (
    input  enable, sampleIn,
    output freqOut, periodOut, valid, noSignal, periodSat
  );
endinterface

// File: rtl/nco_freq_meter.sv
// Recovers the frequency of an NCO sample stream: counts MSB rising edges over
// a 2^GATE_LOG2-clock gate window and measures the clock distance between edges.
module nco_freq_meter #(
  parameter int DATA_W    = 8,
  parameter int GATE_LOG2 = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  nco_freq_meter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [GATE_LOG2-1:0] GATE_ZERO = GATE_LOG2'(0);
  localparam logic [GATE_LOG2-1:0] GATE_ONE  = GATE_LOG2'(1);
  localparam logic [GATE_LOG2-1:0] GATE_LAST = {GATE_LOG2{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]       PER_ZERO  = (CNT_W+1)'(0);
  localparam logic [CNT_W:0]       PER_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]       PER_OVF   = {1'b1, {CNT_W{1'b0}}};

  state_t               state_q, state_d;
  logic                 prev_msb_q;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]     edge_q, edge_d;
  logic [CNT_W:0]       per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]     per_lat_q, per_lat_d;
  logic                 per_sat_lat_q, per_sat_lat_d;
  logic                 have_per_q, have_per_d;
  logic [CNT_W-1:0]     freq_q, freq_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 nosig_q, nosig_d;
  logic                 psat_q, psat_d;

  logic                 msb_s, rise_s, gate_last_s, per_clamp_s;
  logic [CNT_W-1:0]     per_val_s, edge_next_s, lat_next_s;
  logic [CNT_W:0]       per_inc_s;
  logic                 have_next_s, lsat_next_s;

  assign msb_s       = bus.sampleIn[DATA_W-1];
  assign rise_s      = msb_s & ~prev_msb_q;
  assign gate_last_s = (gate_q == GATE_LAST);
  // The period counter has one extra bit and parks at 2^CNT_W to flag overflow.
  assign per_inc_s   = (per_cnt_q == PER_OVF) ? PER_OVF : (per_cnt_q + PER_ONE);
  assign per_clamp_s = (per_cnt_q == PER_OVF);
  assign per_val_s   = per_clamp_s ? CNT_MAX : per_cnt_q[CNT_W-1:0];
  assign edge_next_s = rise_s ? ((edge_q == CNT_MAX) ? edge_q : (edge_q + CNT_ONE)) : edge_q;
  assign have_next_s = have_per_q | rise_s;
  assign lat_next_s  = rise_s ? per_val_s : per_lat_q;
  assign lsat_next_s = rise_s ? per_clamp_s : per_sat_lat_q;

  // Next-state, counter and report logic of the gate FSM.
  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    edge_d        = edge_q;
    per_cnt_d     = per_inc_s;
    per_lat_d     = per_lat_q;
    per_sat_lat_d = per_sat_lat_q;
    have_per_d    = have_per_q;
    freq_d        = freq_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    nosig_d       = nosig_q;
    psat_d        = psat_q;

    if (!bus.enable) begin
      state_d    = IDLE;
      gate_d     = GATE_ZERO;
      edge_d     = CNT_ZERO;
      per_cnt_d  = PER_ZERO;
      have_per_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARM;
          gate_d     = GATE_ZERO;
          edge_d     = CNT_ZERO;
          per_cnt_d  = PER_ZERO;
          have_per_d = 1'b0;
        end
        ARM: begin
          edge_d     = CNT_ZERO;
          have_per_d = 1'b0;
          if (rise_s) begin
            // The arming edge is gate cycle 0 and the first counted edge.
            state_d   = MEASURE;
            gate_d    = GATE_ONE;
            edge_d    = CNT_ONE;
            per_cnt_d = PER_ONE;
          end else if (gate_last_s) begin
            state_d  = ARM;
            gate_d   = GATE_ZERO;
            valid_d  = 1'b1;
            freq_d   = CNT_ZERO;
            period_d = CNT_ZERO;
            nosig_d  = 1'b1;
            psat_d   = 1'b0;
          end else begin
            state_d = ARM;
            gate_d  = gate_q + GATE_ONE;
          end
        end
        MEASURE: begin
          gate_d        = gate_q + GATE_ONE;
          edge_d        = edge_next_s;
          per_lat_d     = lat_next_s;
          per_sat_lat_d = lsat_next_s;
          have_per_d    = have_next_s;
          per_cnt_d     = rise_s ? PER_ONE : per_inc_s;
          if (gate_last_s) begin
            valid_d  = 1'b1;
            freq_d   = edge_next_s;
            period_d = have_next_s ? lat_next_s : CNT_ZERO;
            psat_d   = have_next_s & lsat_next_s;
            nosig_d  = (edge_next_s == CNT_ZERO);
            edge_d   = CNT_ZERO;
            if (edge_next_s == CNT_ZERO) begin
              state_d    = ARM;
              have_per_d = 1'b0;
            end else begin
              state_d = MEASURE;
            end
          end else begin
            state_d = MEASURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; prevMsb tracks the sample every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_msb_q    <= 1'b0;
      gate_q        <= GATE_ZERO;
      edge_q        <= CNT_ZERO;
      per_cnt_q     <= PER_ZERO;
      per_lat_q     <= CNT_ZERO;
      per_sat_lat_q <= 1'b0;
      have_per_q    <= 1'b0;
      freq_q        <= CNT_ZERO;
      period_q      <= CNT_ZERO;
      valid_q       <= 1'b0;
      nosig_q       <= 1'b0;
      psat_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_msb_q    <= msb_s;
      gate_q        <= gate_d;
      edge_q        <= edge_d;
      per_cnt_q     <= per_cnt_d;
      per_lat_q     <= per_lat_d;
      per_sat_lat_q <= per_sat_lat_d;
      have_per_q    <= have_per_d;
      freq_q        <= freq_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      nosig_q       <= nosig_d;
      psat_q        <= psat_d;
    end
  end

  assign bus.freqOut   = freq_q;
  assign bus.periodOut = period_q;
  assign bus.valid     = valid_q;
  assign bus.noSignal  = nosig_q;
  assign bus.periodSat = psat_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Self-checking bench for nco_freq_meter: directed scenarios plus randomized
// tone/noise segments, checked every cycle against a time-stamp based model.
module tb_nco_freq_meter;
  localparam int DATA_W    = 8;
  localparam int GATE_LOG2 = 8;
  localparam int CNT_W     = 16;
  localparam int WIN       = 1 << GATE_LOG2;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nco_freq_meter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  nco_freq_meter #(.DATA_W(DATA_W), .GATE_LOG2(GATE_LOG2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: mode 0 idle, 1 waiting for edge, 2 measuring; windows and
  // periods are tracked as absolute cycle stamps rather than counters.
  int m_mode = 0, m_win = 0, m_edges = 0, m_last = 0, m_per = 0;
  bit m_prev = 1'b0, m_have = 1'b0, m_psat = 1'b0;
  int e_freq = 0, e_per = 0;
  bit e_valid = 1'b0, e_nosig = 1'b0, e_psat = 1'b0;

  // Stimulus state.
  int        smode = 0;
  int        ftw   = 16;
  logic [7:0] acc  = 8'h00;
  bit        alt   = 1'b0;

  // Observed reports for directed spot checks.
  int last_f = 0, last_p = 0, first_f = -1, first_p = -1, n_valid = 0;
  bit last_ns = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic report(input int f, input int p, input bit ns, input bit ps);
    e_valid = 1'b1;
    e_freq  = f;
    e_per   = p;
    e_nosig = ns;
    e_psat  = ps;
  endtask

  task automatic model_update();
    bit msb, rise;
    int p;
    msb    = bus.sampleIn[DATA_W-1];
    rise   = msb && !m_prev;
    m_prev = msb;
    e_valid = 1'b0;
    if (rst) begin
      m_mode = 0; m_prev = 1'b0; m_edges = 0; m_have = 1'b0;
      e_freq = 0; e_per = 0; e_nosig = 1'b0; e_psat = 1'b0;
    end else if (!bus.enable) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          m_mode = 1;
          m_win  = cyc + 1;
        end
        1: begin
          if (rise) begin
            m_mode = 2; m_win = cyc; m_edges = 1; m_last = cyc; m_have = 1'b0;
          end else if (cyc - m_win == WIN - 1) begin
            report(0, 0, 1'b1, 1'b0);
            m_win = cyc + 1;
          end
        end
        default: begin
          if (rise) begin
            if (m_edges < CMAX) m_edges++;
            p = cyc - m_last;
            m_psat = (p > CMAX);
            m_per  = m_psat ? CMAX : p;
            m_have = 1'b1;
            m_last = cyc;
          end
          if (cyc - m_win == WIN - 1) begin
            report(m_edges, m_have ? m_per : 0, m_edges == 0, m_have ? m_psat : 1'b0);
            if (m_edges == 0) begin
              m_mode = 1;
              m_have = 1'b0;
            end
            m_edges = 0;
            m_win   = cyc + 1;
          end
        end
      endcase
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_val("valid",     32'(bus.valid),     32'(e_valid));
    check_val("freqOut",   32'(bus.freqOut),   32'(e_freq));
    check_val("periodOut", 32'(bus.periodOut), 32'(e_per));
    check_val("noSignal",  32'(bus.noSignal),  32'(e_nosig));
    check_val("periodSat", 32'(bus.periodSat), 32'(e_psat));
    if (bus.valid === 1'b1) begin
      last_f  = int'(bus.freqOut);
      last_p  = int'(bus.periodOut);
      last_ns = bus.noSignal;
      if (n_valid == 0) begin
        first_f = int'(bus.freqOut);
        first_p = int'(bus.periodOut);
      end
      n_valid++;
    end
  endtask

  task automatic drive();
    case (smode)
      0: begin acc = acc + 8'(ftw); bus.sampleIn = acc; end
      1: bus.sampleIn = 8'h00;
      2: begin alt = ~alt; bus.sampleIn = alt ? 8'h80 : 8'h00; end
      default: bus.sampleIn = 8'($urandom);
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic phase(input int mode, input int f);
    smode = mode; ftw = f; n_valid = 0; first_f = -1; first_p = -1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable   = 1'b1;
    bus.sampleIn = 8'h00;
    run(3);
    rst = 1'b0;

    // Sawtooth FTW=16, then reset in the middle of a window.
    phase(0, 16);
    run(700);
    check_val("saw16_freq", 32'(last_f), 32'd16);
    check_val("saw16_per",  32'(last_p), 32'd16);
    check_val("saw16_nval", 32'(n_valid >= 2), 32'd1);
    run(100);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    phase(0, 16);
    run(600);
    check_val("rst_rearm_freq", 32'(first_f), 32'd16);

    // Slowest tone from a clean start.
    rst = 1'b1; acc = 8'h00;
    run(2);
    rst = 1'b0;
    phase(0, 1);
    run(1000);
    check_val("ftw1_first_freq", 32'(first_f), 32'd1);
    check_val("ftw1_first_per",  32'(first_p), 32'd0);
    check_val("ftw1_freq",       32'(last_f),  32'd1);
    check_val("ftw1_per",        32'(last_p),  32'd256);

    // DC input, then back to a tone.
    phase(1, 0);
    run(800);
    check_val("dc_freq",  32'(last_f),  32'd0);
    check_val("dc_per",   32'(last_p),  32'd0);
    check_val("dc_nosig", 32'(last_ns), 32'd1);
    phase(0, 16);
    run(700);

    // Enable drop mid-window.
    run(100);
    bus.enable = 1'b0;
    phase(0, 16);
    run(50);
    check_val("endrop_nval", 32'(n_valid), 32'd0);
    check_val("endrop_hold", 32'(bus.freqOut), 32'd16);
    bus.enable = 1'b1;
    run(700);
    check_val("reen_freq", 32'(first_f), 32'd16);
    check_val("reen_per",  32'(first_p), 32'd16);

    // Maximum rate, with a one-cycle phase slip so edges land on odd gate cycles.
    phase(2, 0);
    run(600);
    bus.sampleIn = 8'h00; alt = 1'b0;
    step();
    run(800);
    check_val("max_freq", 32'(last_f), 32'd128);
    check_val("max_per",  32'(last_p), 32'd2);

    // Randomized segments: tones, noise, DC, alternation, enable drops, resets.
    for (int s = 0; s < 14; s++) begin
      phase(int'($urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0), int'($urandom_range(1, 40)));
      bus.enable = ($urandom_range(0, 5) != 0);
      rst = ($urandom_range(0, 7) == 0);
      run(1);
      rst = 1'b0;
      run(int'($urandom_range(200, 900)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
